// File: rtl/apb4_mem_slv_ws.sv
// APB4 memory completer with alignment/range checks, fixed wait states and a privileged-write region.
// Errors and read data are presented on the final access cycle only.
module apb4_mem_slv_ws #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 2,
  parameter int PROT_WORDS  = 4
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [ADDR_WIDTH-1:0]     PADDR,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [DATA_WIDTH-1:0]     PWDATA,
  input  logic [DATA_WIDTH/8-1:0]   PSTRB,
  input  logic [2:0]                PPROT,
  output logic                      PREADY,
  output logic [DATA_WIDTH-1:0]     PRDATA,
  output logic                      PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int WORD_ADDR  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   MEM_BYTES  = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [3:0]            WS         = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt;
  logic [WORD_ADDR-1:0]   idx, idx_q;
  logic                   err_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  logic setup, ready, commit;
  logic out_of_range, misaligned, prot_hit, err_setup;

  assign idx          = PADDR[ADDR_LSB +: WORD_ADDR];
  assign setup        = (state == IDLE) && PSEL && !PENABLE;
  assign out_of_range = {1'b0, PADDR} >= MEM_BYTES;
  assign misaligned   = |(PADDR & ALIGN_MASK);
  assign prot_hit     = 32'(idx) < PROT_WORDS;
  assign err_setup    = out_of_range || misaligned || (PWRITE && prot_hit && !PPROT[0]);
  assign ready        = (state == ACCESS) && (cnt == 4'd0);
  assign commit       = ready && PSEL && PENABLE && PWRITE && !err_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (PSEL && !PENABLE) state_nxt = ACCESS;
      ACCESS:  if (!PSEL || (PENABLE && ready)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PREADY  = ready;
    PSLVERR = ready && err_q;
    PRDATA  = (ready && !PWRITE && !err_q) ? rdata_q : '0;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt     <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (setup) begin
      cnt   <= WS;
      idx_q <= idx;
      err_q <= err_setup;
      if (!PWRITE) rdata_q <= mem[idx];
    end else if (state == ACCESS && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Memory is not reset, but a reset edge must never let a pending write land.
  always_ff @(posedge PCLK) begin
    if (!PRESET && commit) begin
      for (int i = 0; i < STRB_WIDTH; i++)
        if (PSTRB[i]) mem[idx_q][8*i +: 8] <= PWDATA[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_apb4_mem_slv_ws.sv
// Bench for apb4_mem_slv_ws: a 2-wait-state instance and a 0-wait-state instance
// checked against a word-array reference model.
module tb_apb4_mem_slv_ws;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] paddr = '0;
  logic        psel2 = 1'b0, psel0 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = '0;
  logic        rdy2, rdy0, err2, err0;
  logic [31:0] rd2, rd0;

  int errors = 0;
  int checks = 0;

  logic [31:0] model2 [64];
  logic [31:0] model0 [64];

  always #5 clk = ~clk;

  apb4_mem_slv_ws #(.WAIT_STATES(2)) dut2 (
    .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PSEL(psel2), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PREADY(rdy2), .PRDATA(rd2), .PSLVERR(err2)
  );

  apb4_mem_slv_ws #(.WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PSEL(psel0), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PREADY(rdy0), .PRDATA(rd0), .PSLVERR(err0)
  );

  function automatic bit exp_err(input logic [31:0] addr, input bit wr, input logic [2:0] prot);
    return (addr >= 32'd256) || (addr % 4 != 0) || (wr && (addr / 4) < 4 && !prot[0]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One APB transfer; returns at the negedge of the completing cycle so a
  // following call issues its setup phase back-to-back.
  task automatic xfer(input bit use0, input logic [31:0] addr, input bit wr,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] prot,
                      output logic [31:0] rd, output logic err, output int cyc, output bit early);
    bit done = 0;
    @(posedge clk); #1;
    psel0 = use0; psel2 = !use0; penable = 1'b0;
    paddr = addr; pwrite = wr; pwdata = wd; pstrb = st; pprot = prot;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 0; early = 0; rd = 'x; err = 1'bx;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (use0 ? rdy0 : rdy2) begin
        rd = use0 ? rd0 : rd2;
        err = use0 ? err0 : err2;
        done = 1;
      end else begin
        if ((use0 ? err0 : err2) !== 1'b0 || (use0 ? rd0 : rd2) !== 32'd0) early = 1;
        @(posedge clk); #1;
      end
    end
    if (!done) cyc = -1;
    if (wr && !exp_err(addr, wr, prot)) begin
      if (use0) model0[addr/4] = merge(model0[addr/4], wd, st);
      else      model2[addr/4] = merge(model2[addr/4], wd, st);
    end
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (rdy2 !== 1'b0 || rdy0 !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b/%b want 0", rdy2, rdy0); end
    checks++; if (err2 !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b/%b want 0", err2, err0); end
    checks++; if (rd2 !== 32'd0 || rd0 !== 32'd0) begin errors++; $display("FAIL reset_prdata: got %h/%h want 0", rd2, rd0); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [31:0] rd; logic err; int cyc; bit early;
    for (int w = 0; w < 64; w++) begin
      xfer(0, 32'(w*4), 1, $urandom, 4'hF, 3'b001, rd, err, cyc, early);
      checks++; if (err !== 1'b0 || cyc != 3) begin errors++; $display("FAIL fill_w%0d: err=%b cyc=%0d want err=0 cyc=3", w, err, cyc); end
    end
    bus_idle();
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic err; int cyc; bit early;
    xfer(0, 32'h10, 1, 32'hDEADBEEF, 4'hF, 3'b000, rd, err, cyc, early);
    checks++; if (cyc != 3 || err !== 1'b0 || early) begin errors++; $display("FAIL basic_wr: cyc=%0d err=%b early=%0d want 3/0/0", cyc, err, early); end
    xfer(0, 32'h10, 0, 0, 4'h0, 3'b000, rd, err, cyc, early);
    checks++; if (cyc != 3 || early) begin errors++; $display("FAIL basic_rd_len: cyc=%0d early=%0d want 3/0", cyc, early); end
    checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin errors++; $display("FAIL basic_rd: rd=%h err=%b want deadbeef/0", rd, err); end
    xfer(0, 32'h10, 1, 32'h11223344, 4'b0101, 3'b000, rd, err, cyc, early);
    xfer(0, 32'h10, 0, 0, 4'h0, 3'b000, rd, err, cyc, early);
    checks++; if (rd !== 32'hDE22BE44 || err !== 1'b0) begin errors++; $display("FAIL strobe_rd: rd=%h err=%b want de22be44/0", rd, err); end
    xfer(0, 32'h10, 1, 32'hCAFEF00D, 4'h0, 3'b000, rd, err, cyc, early);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_strb_err: got %b want 0", err); end
    bus_idle();
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int cyc; bit early;
    xfer(0, 32'h100, 0, 0, 4'h0, 3'b001, rd, err, cyc, early);
    checks++; if (err !== 1'b1 || rd !== 32'd0 || cyc != 3 || early) begin errors++; $display("FAIL oor_rd: err=%b rd=%h cyc=%0d early=%0d want 1/0/3/0", err, rd, cyc, early); end
    xfer(0, 32'h12, 1, 32'hFFFFFFFF, 4'hF, 3'b001, rd, err, cyc, early);
    checks++; if (err !== 1'b1 || early) begin errors++; $display("FAIL misal_wr: err=%b early=%0d want 1/0", err, early); end
    xfer(0, 32'h10, 0, 0, 4'h0, 3'b000, rd, err, cyc, early);
    checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL misal_keep: rd=%h want de22be44", rd); end
    bus_idle();
  endtask

  task automatic test_protection();
    logic [31:0] rd; logic err; int cyc; bit early;
    logic [31:0] old = model2[1];
    xfer(0, 32'h04, 1, 32'hA5A5A5A5, 4'hF, 3'b000, rd, err, cyc, early);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL prot_wr_unpriv: err=%b want 1", err); end
    xfer(0, 32'h04, 0, 0, 4'h0, 3'b000, rd, err, cyc, early);
    checks++; if (rd !== old || err !== 1'b0) begin errors++; $display("FAIL prot_keep: rd=%h err=%b want %h/0", rd, err, old); end
    xfer(0, 32'h04, 1, 32'hA5A5A5A5, 4'hF, 3'b001, rd, err, cyc, early);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL prot_wr_priv: err=%b want 0", err); end
    xfer(0, 32'h04, 0, 0, 4'h0, 3'b000, rd, err, cyc, early);
    checks++; if (rd !== 32'hA5A5A5A5 || err !== 1'b0) begin errors++; $display("FAIL prot_rd: rd=%h err=%b want a5a5a5a5/0", rd, err); end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int cyc; bit early;
    logic [31:0] old = model2[8];
    @(posedge clk); #1;
    psel2 = 1; penable = 0; paddr = 32'h20; pwrite = 1; pwdata = 32'h12345678; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    checks++; if (rdy2 !== 1'b0 || err2 !== 1'b0 || rd2 !== 32'd0) begin errors++; $display("FAIL rst_mid_wr: rdy=%b err=%b rd=%h want 0", rdy2, err2, rd2); end
    @(posedge clk); #1;
    psel2 = 0; penable = 0; rst = 1'b0;
    xfer(0, 32'h20, 0, 0, 4'h0, 3'b000, rd, err, cyc, early);
    checks++; if (rd !== old || err !== 1'b0) begin errors++; $display("FAIL rst_keep: rd=%h err=%b want %h/0", rd, err, old); end
    bus_idle();
    // Reset landing while a read is presenting data must clear outputs at once.
    @(posedge clk); #1;
    psel2 = 1; penable = 0; paddr = 32'h10; pwrite = 0;
    @(posedge clk); #1 penable = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdy2 !== 1'b1 || rd2 !== model2[4]) begin errors++; $display("FAIL rst_rd_pre: rdy=%b rd=%h want 1/%h", rdy2, rd2, model2[4]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rdy2 !== 1'b0 || rd2 !== 32'd0 || err2 !== 1'b0) begin errors++; $display("FAIL rst_async: rdy=%b rd=%h err=%b want 0", rdy2, rd2, err2); end
    @(posedge clk); #1;
    psel2 = 0; penable = 0; rst = 1'b0;
  endtask

  task automatic test_zero_ws();
    logic [31:0] rd; logic err; int cyc; bit early;
    logic [31:0] wv [4];
    for (int i = 0; i < 4; i++) begin
      wv[i] = $urandom;
      xfer(1, 32'(i*4), 1, wv[i], 4'hF, 3'b001, rd, err, cyc, early);
      checks++; if (cyc != 1 || err !== 1'b0) begin errors++; $display("FAIL ws0_wr%0d: cyc=%0d err=%b want 1/0", i, cyc, err); end
    end
    for (int i = 0; i < 4; i++) begin
      xfer(1, 32'(i*4), 0, 0, 4'h0, 3'b000, rd, err, cyc, early);
      checks++; if (rd !== wv[i] || rd !== model0[i] || cyc != 1) begin errors++; $display("FAIL ws0_rd%0d: rd=%h cyc=%0d want %h/1", i, rd, cyc, wv[i]); end
    end
    bus_idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int cyc; bit early;
    logic [31:0] old = model2[12];
    @(posedge clk); #1;
    psel2 = 1; penable = 0; paddr = 32'h30; pwrite = 1; pwdata = ~old; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 psel2 = 0; penable = 0;
    repeat (4) @(posedge clk);
    xfer(0, 32'h30, 0, 0, 4'h0, 3'b000, rd, err, cyc, early);
    checks++; if (rd !== old || cyc != 3 || err !== 1'b0) begin errors++; $display("FAIL abort: rd=%h cyc=%0d err=%b want %h/3/0", rd, cyc, err, old); end
    bus_idle();
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd, exp; logic err; int cyc; bit early, wr, ee;
    logic [3:0] st; logic [2:0] prot;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        7:       addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
        8:       addr = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(64, 1023) * 4) : ($urandom | 32'h8000_0000) & ~32'h3;
        9:       addr = 32'($urandom_range(0, 3) * 4);
        default: addr = 32'($urandom_range(0, 63) * 4);
      endcase
      wr = $urandom_range(0, 1) != 0;
      wd = $urandom; st = 4'($urandom); prot = 3'($urandom);
      ee = exp_err(addr, wr, prot);
      exp = (wr || ee) ? 32'd0 : model2[addr[7:2]];
      xfer(0, addr, wr, wd, st, prot, rd, err, cyc, early);
      checks++;
      if (cyc != 3 || err !== ee || rd !== exp || early) begin
        errors++;
        $display("FAIL rand%0d addr=%h wr=%0d: cyc=%0d err=%b rd=%h early=%0d want 3/%b/%h/0", n, addr, wr, cyc, err, rd, early, ee, exp);
      end
      if ($urandom_range(0, 4) == 0) bus_idle();
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_errors();
    test_protection();
    test_reset_mid();
    test_zero_ws();
    test_abort();
    test_random();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
